// File: rtl/data_sram_responder.sv
// Data-SRAM responder for the MEM stage: registered handshake, byte-masked writes,
// full-word reads, optional wait states with a busy stall indication.
module data_sram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:2] r_addr;
  logic [3:0]  r_wen;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_ack;
  logic        r_err;
  logic        r_busy;
  logic [31:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_wait_done;
  logic                  w_commit;
  logic [31:2]           w_addr;
  logic [3:0]            w_wen;
  logic [31:0]           w_wdata;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_oor;
  logic                  w_is_wr;

  // With no wait states the access commits on its accepting edge straight from the
  // request inputs; otherwise it commits from the latched copy when WAIT expires.
  always_comb begin
    w_accept    = req_valid && (r_state != S_WAIT);
    w_wait_done = (r_state == S_WAIT) && (r_cnt == 4'd0);
    w_commit    = !rst && (w_wait_done || (w_accept && (WAIT_CYCLES == 0)));
    w_addr      = w_wait_done ? r_addr  : req_addr[31:2];
    w_wen       = w_wait_done ? r_wen   : req_wen;
    w_wdata     = w_wait_done ? r_wdata : req_wdata;
    w_idx       = w_addr[ADDR_WIDTH+1:2];
    w_oor       = |w_addr[31:ADDR_WIDTH+2];
    w_is_wr     = |w_wen;
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_is_wr && !w_oor) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_wen[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wen   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= w_commit;
      r_err <= w_commit && w_oor;
      if (w_commit && !w_is_wr) r_rdata <= w_oor ? '0 : r_mem[w_idx];

      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            r_addr  <= req_addr[31:2];
            r_wen   <= req_wen;
            r_wdata <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_LOAD;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: three responders (0, 3 and 2 wait states) driven with directed
// and random accesses, checked against a word-array model of the memory.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rst       [3];
  logic        req_valid [3];
  logic [31:0] req_addr  [3];
  logic [3:0]  req_wen   [3];
  logic [31:0] req_wdata [3];
  logic [31:0] rdata     [3];
  logic        ack       [3];
  logic        err       [3];
  logic        busy      [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_mem   [3][1024];
  bit          m_kn    [3][1024];
  logic [31:0] m_rd    [3];
  bit          m_rd_kn [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_sram_responder #(
      .ADDR_WIDTH (10),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .req_valid(req_valid[g]),
      .req_addr (req_addr[g]),
      .req_wen  (req_wen[g]),
      .req_wdata(req_wdata[g]),
      .rdata    (rdata[g]),
      .ack      (ack[g]),
      .err      (err[g]),
      .busy     (busy[g])
    );
  end

  function automatic int wc(int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_reset(int k);
    rst[k] = 1'b1;
    #1;
    check("rst_rdata", rdata[k], 32'h0);
    check("rst_ack", 32'(ack[k]), 32'h0);
    check("rst_err", 32'(err[k]), 32'h0);
    check("rst_busy", 32'(busy[k]), 32'h0);
    @(posedge clk); #1;
    rst[k]     = 1'b0;
    m_rd[k]    = '0;
    m_rd_kn[k] = 1'b1;
  endtask

  // Model update happens when the access is expected to complete.
  task automatic model_commit(int k, logic [31:0] a, logic [3:0] wen, logic [31:0] wd);
    bit oor;
    int idx;
    oor = (a[31:12] != 20'h0);
    idx = int'(a[11:2]);
    if (wen != 4'h0) begin
      if (!oor) begin
        for (int b = 0; b < 4; b++)
          if (wen[b]) m_mem[k][idx][8*b +: 8] = wd[8*b +: 8];
        if (wen == 4'hF) m_kn[k][idx] = 1'b1;
      end
    end else if (oor) begin
      m_rd[k] = '0;
      m_rd_kn[k] = 1'b1;
    end else begin
      m_rd[k] = m_mem[k][idx];
      m_rd_kn[k] = m_kn[k][idx];
    end
  endtask

  task automatic access(int k, logic [31:0] a, logic [3:0] wen, logic [31:0] wd,
                        bit keep, bit junk);
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    req_wen[k]   = wen;
    req_wdata[k] = wd;
    @(posedge clk); #1;
    for (int j = 0; j < wc(k); j++) begin
      check("wait_busy", 32'(busy[k]), 32'h1);
      check("wait_ack", 32'(ack[k]), 32'h0);
      if (junk) begin
        req_addr[k]  = $urandom;
        req_wen[k]   = 4'($urandom);
        req_wdata[k] = $urandom;
      end
      @(posedge clk); #1;
    end
    if (!keep) req_valid[k] = 1'b0;
    model_commit(k, a, wen, wd);
    check("ack", 32'(ack[k]), 32'h1);
    check("err", 32'(err[k]), 32'(a[31:12] != 20'h0));
    check("resp_busy", 32'(busy[k]), 32'h0);
    if (m_rd_kn[k]) check("rdata", rdata[k], m_rd[k]);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_addr[k] = '0;
      req_wen[k] = '0; req_wdata[k] = '0;
      for (int i = 0; i < 1024; i++) begin m_mem[k][i] = '0; m_kn[k][i] = 1'b0; end
    end
    for (int k = 0; k < 3; k++) do_reset(k);

    // Zero wait states: basic write/read
    access(0, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0);
    access(0, 32'h10, 4'h0, 32'h0, 0, 0);
    check("dir_rd", rdata[0], 32'hDEADBEEF);

    // Partial writes
    access(0, 32'h20, 4'hF, 32'h11223344, 0, 0);
    access(0, 32'h20, 4'b0010, 32'h0000AA00, 0, 0);
    access(0, 32'h20, 4'h0, 32'h0, 0, 0);
    check("part_rd1", rdata[0], 32'h1122AA44);
    access(0, 32'h20, 4'b1100, 32'h55660000, 0, 0);
    access(0, 32'h20, 4'h0, 32'h0, 0, 0);
    check("part_rd2", rdata[0], 32'h5566AA44);

    // Out of range
    access(0, 32'h0, 4'hF, 32'hCAFEF00D, 0, 0);
    access(0, 32'h1000, 4'hF, 32'h12345678, 0, 0);
    access(0, 32'h0, 4'h0, 32'h0, 0, 0);
    check("oor_word0", rdata[0], 32'hCAFEF00D);
    access(0, 32'h1000, 4'h0, 32'h0, 0, 0);
    check("oor_rd", rdata[0], 32'h0);

    // Back-to-back writes then reads, one ack per cycle
    for (int i = 0; i < 8; i++) access(0, 32'(i * 4), 4'hF, $urandom, 1, 0);
    for (int i = 0; i < 8; i++) access(0, 32'(i * 4), 4'h0, 32'h0, (i != 7), 0);

    // Read-after-write in the write's RESP cycle
    access(0, 32'h40, 4'hF, 32'hA5A5C3C3, 1, 0);
    access(0, 32'h40, 4'h0, 32'h0, 0, 0);
    check("raw", rdata[0], 32'hA5A5C3C3);

    // Reset during RESP: write already committed, outputs clear at once
    req_valid[0] = 1'b1; req_addr[0] = 32'h44; req_wen[0] = 4'hF; req_wdata[0] = 32'h0BADF00D;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("resp_ack", 32'(ack[0]), 32'h1);
    rst[0] = 1'b1; #1;
    check("resp_rst_ack", 32'(ack[0]), 32'h0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    model_commit(0, 32'h44, 4'hF, 32'h0BADF00D);
    m_rd[0] = '0; m_rd_kn[0] = 1'b1;
    access(0, 32'h44, 4'h0, 32'h0, 0, 0);
    check("resp_rst_data", rdata[0], 32'h0BADF00D);

    // Three wait states, junk requests during WAIT are ignored
    access(1, 32'h8, 4'hF, 32'h01020304, 0, 0);
    access(1, 32'hC, 4'hF, 32'h0A0B0C0D, 0, 0);
    access(1, 32'h8, 4'h0, 32'h0, 0, 1);
    check("w3_rd", rdata[1], 32'h01020304);
    access(1, 32'hC, 4'h0, 32'h0, 0, 1);
    check("w3_rd2", rdata[1], 32'h0A0B0C0D);

    // Two wait states, reset while in WAIT drops the access
    access(2, 32'h30, 4'hF, 32'h13579BDF, 0, 0);
    req_valid[2] = 1'b1; req_addr[2] = 32'h30; req_wen[2] = 4'hF; req_wdata[2] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1; #1;
    check("wrst_busy", 32'(busy[2]), 32'h0);
    check("wrst_ack", 32'(ack[2]), 32'h0);
    for (int i = 0; i < 2; i++) begin @(posedge clk); #1; check("wrst_ack_hold", 32'(ack[2]), 32'h0); end
    rst[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; check("wrst_ack_after", 32'(ack[2]), 32'h0); end
    m_rd[2] = '0; m_rd_kn[2] = 1'b1;
    access(2, 32'h30, 4'h0, 32'h0, 0, 0);
    check("wrst_old", rdata[2], 32'h13579BDF);

    // Random traffic on all three responders
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 60; n++) begin
        logic [31:0] a;
        logic [3:0]  wen;
        a = 32'(($urandom % 16) * 4);
        if ($urandom % 8 == 0) a = a | (32'h1000 << ($urandom % 20));
        wen = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
        access(k, a, wen, $urandom, (k == 0) && (n != 59) && ($urandom % 2 == 1),
               ($urandom % 2 == 1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
